// File: rtl/writeback_controller_if.sv
// Result/issue/write-port bundle between the execution units, decode and the register file.
// Port summary: ALU and load result channels (valid/ready), decode issue channel
// (valid/ready), scoreboard pending vector, and the register-file write port.
// The controller is the slave side; producers, decode and the register file form the master side.
interface writeback_controller_if;
    // ALU result channel
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [17:0] alu_data;
    logic        alu_ready;

    // Load result channel
    logic        load_valid;
    logic [3:0]  load_dest;
    logic [17:0] load_data;
    logic        load_ready;

    // Decode issue channel and hazard view
    logic        issue_valid;
    logic [3:0]  issue_dest;
    logic        issue_ready;
    logic [15:0] pending;

    // Register-file write port
    logic [3:0]  write_reg;
    logic [17:0] write_data;
    logic        reg_write_enable;

    modport master (
        output alu_valid, alu_dest, alu_data,
        input  alu_ready,
        output load_valid, load_dest, load_data,
        input  load_ready,
        output issue_valid, issue_dest,
        input  issue_ready, pending,
        input  write_reg, write_data, reg_write_enable
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        output alu_ready,
        input  load_valid, load_dest, load_data,
        output load_ready,
        input  issue_valid, issue_dest,
        output issue_ready, pending,
        output write_reg, write_data, reg_write_enable
    );
endinterface

// File: rtl/writeback_controller.sv
// Serialises ALU and load results in order onto the single register-file write port; tracks in-flight writes per register.
// Latency: accepted at edge N into an empty FIFO -> write strobe during cycle N+1; each older queued entry adds one cycle.
// Backpressure: LOAD_READY/ALU_READY from FIFO occupancy only; ISSUE_READY drops when the destination already has 3 writes in flight.
// Ports: cpu_clock, clear (synchronous, active-high); bus (slave modport) carries the result,
// issue, pending and register-file write signals.
module writeback_controller #(
    parameter int DEPTH = 4
) (
    input  logic                   cpu_clock,
    input  logic                   clear,
    writeback_controller_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0]  dest;
        logic [17:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // Result FIFO state
    // ------------------------------------------------------------------
    entry_t        fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;
    logic [PW:0]   free_slots;

    logic          load_ready;
    logic          alu_ready;
    logic          load_acc;
    logic          alu_acc;
    logic [1:0]    acc_cnt;
    logic          deq;
    logic [PW-1:0] alu_slot;
    entry_t        load_entry;
    entry_t        alu_entry;
    entry_t        head;

    // Register-file write port registers
    logic [3:0]    wr_reg_q;
    logic [17:0]   wr_data_q;
    logic          wr_en_q;

    // Scoreboard
    logic [1:0]    sb_cnt [16];
    logic [15:0]   inc_vec;
    logic [15:0]   dec_vec;
    logic [15:0]   pending_vec;
    logic          issue_ready;
    logic          issue_acc;

    // ------------------------------------------------------------------
    // Ready generation: a function of occupancy only. The ALU needs two
    // free slots when a load may claim one this cycle; the same-cycle
    // dequeue is deliberately not credited so the ready path stays short.
    // ------------------------------------------------------------------
    always_comb begin
        free_slots = DEPTH_W - occ;
        load_ready = (free_slots != '0);
        alu_ready  = (free_slots >= (PW + 1)'(2)) ||
                     ((free_slots != '0) && !bus.load_valid);
    end

    assign load_acc = bus.load_valid & load_ready;
    assign alu_acc  = bus.alu_valid  & alu_ready;
    assign acc_cnt  = {1'b0, load_acc} + {1'b0, alu_acc};
    assign deq      = (occ != '0);

    // The load is older in program order, so it takes the first free slot
    // and the ALU result lands behind it when both arrive together.
    assign alu_slot   = wr_ptr + PW'(load_acc);
    assign load_entry = '{dest: bus.load_dest, data: bus.load_data};
    assign alu_entry  = '{dest: bus.alu_dest,  data: bus.alu_data};
    assign head       = fifo_mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge cpu_clock) begin
        if (!clear) begin
            if (load_acc) begin
                fifo_mem[wr_ptr] <= load_entry;
            end
            if (alu_acc) begin
                fifo_mem[alu_slot] <= alu_entry;
            end
        end
    end

    // Pointer, occupancy and write-port registers. Every result goes through
    // the FIFO (no empty bypass) so latency does not depend on occupancy history.
    always_ff @(posedge cpu_clock) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(acc_cnt);
            rd_ptr  <= rd_ptr + PW'(deq);
            occ     <= occ + (PW + 1)'(acc_cnt) - (PW + 1)'(deq);
            wr_en_q <= deq;
            // Address and data hold their last value between strobes.
            if (deq) begin
                wr_reg_q  <= head.dest;
                wr_data_q <= head.data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: 2-bit in-flight count per register. The decrement is
    // taken on the edge that ends the strobe cycle, which is the same
    // edge the register file commits the value, so a stalled reader
    // never sees PENDING drop before the data is architecturally visible.
    // ------------------------------------------------------------------
    assign issue_ready = (sb_cnt[bus.issue_dest] != 2'd3);
    assign issue_acc   = bus.issue_valid & issue_ready;

    always_comb begin
        inc_vec     = '0;
        dec_vec     = '0;
        pending_vec = '0;
        for (int i = 0; i < 16; i++) begin
            inc_vec[i]     = issue_acc && (bus.issue_dest == 4'(i));
            // A decrement at zero is dropped so the count cannot wrap to 3.
            dec_vec[i]     = wr_en_q && (wr_reg_q == 4'(i)) && (sb_cnt[i] != 2'd0);
            pending_vec[i] = (sb_cnt[i] != 2'd0);
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                sb_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   sb_cnt[i] <= sb_cnt[i] + 2'd1;
                    2'b01:   sb_cnt[i] <= sb_cnt[i] - 2'd1;
                    default: sb_cnt[i] <= sb_cnt[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.load_ready       = load_ready;
    assign bus.alu_ready        = alu_ready;
    assign bus.issue_ready      = issue_ready;
    assign bus.pending          = pending_vec;
    assign bus.write_reg        = wr_reg_q;
    assign bus.write_data       = wr_data_q;
    assign bus.reg_write_enable = wr_en_q;

endmodule

// File: tb/tb_writeback_controller.sv
// Directed bench for writeback_controller with a reference queue and scoreboard model.
// Results are pushed to the expected queue on acceptance and popped when the write port strobes.
// Directed steps follow the feature list: reset, single/dual results, saturation, hazard counts, clear, wrap.
module tb_writeback_controller;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  dest;
        logic [17:0] data;
    } ent_t;

    logic cpu_clock;
    logic clear;

    writeback_controller_if bus ();

    writeback_controller #(.DEPTH(DEPTH)) dut (
        .cpu_clock (cpu_clock),
        .clear     (clear),
        .bus       (bus)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    int tests = 0;
    int fails = 0;

    // Reference state
    ent_t        exp_q [$];
    logic        exp_we   = 1'b0;
    logic [3:0]  exp_reg  = '0;
    logic [17:0] exp_data = '0;
    logic [1:0]  m_cnt [16];
    int          pushes   = 0;
    int          dropped  = 0;
    int          writes_seen = 0;
    bit          checking = 1'b0;
    bit          saw_throttle = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    // Reference model, evaluated on each active edge against the inputs held there.
    always @(posedge cpu_clock) begin
        int   mfree;
        bit   lr, ar, iss;
        ent_t e;
        if (clear) begin
            dropped += exp_q.size();
            exp_q.delete();
            exp_we   = 1'b0;
            exp_reg  = '0;
            exp_data = '0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 2'd0;
        end else begin
            iss = bus.issue_valid && (m_cnt[bus.issue_dest] != 2'd3);
            for (int i = 0; i < 16; i++) begin
                bit inc, dec;
                inc = iss && (bus.issue_dest == 4'(i));
                dec = exp_we && (exp_reg == 4'(i)) && (m_cnt[i] != 2'd0);
                if (inc && !dec) m_cnt[i] = m_cnt[i] + 2'd1;
                else if (dec && !inc) m_cnt[i] = m_cnt[i] - 2'd1;
            end
            mfree = DEPTH - exp_q.size();
            lr = (mfree >= 1);
            ar = (mfree >= 2) || ((mfree >= 1) && !bus.load_valid);
            if (exp_q.size() != 0) begin
                e        = exp_q.pop_front();
                exp_we   = 1'b1;
                exp_reg  = e.dest;
                exp_data = e.data;
            end else begin
                exp_we = 1'b0;
            end
            if (bus.load_valid && lr) begin
                exp_q.push_back('{dest: bus.load_dest, data: bus.load_data});
                pushes++;
            end
            if (bus.alu_valid && ar) begin
                exp_q.push_back('{dest: bus.alu_dest, data: bus.alu_data});
                pushes++;
            end
        end
    end

    // Output monitor on the inactive edge.
    always @(negedge cpu_clock) begin
        if (checking) begin
            int          mfree;
            logic [15:0] exp_pend;
            mfree = DEPTH - exp_q.size();
            for (int i = 0; i < 16; i++) exp_pend[i] = (m_cnt[i] != 2'd0);
            check("mon_we", 32'(bus.reg_write_enable), 32'(exp_we));
            if (exp_we) begin
                check("mon_reg",  32'(bus.write_reg),  32'(exp_reg));
                check("mon_data", 32'(bus.write_data), 32'(exp_data));
            end
            check("mon_load_ready", 32'(bus.load_ready), 32'(mfree >= 1));
            check("mon_alu_ready",  32'(bus.alu_ready),
                  32'((mfree >= 2) || ((mfree >= 1) && !bus.load_valid)));
            check("mon_pending", 32'(bus.pending), 32'(exp_pend));
            check("mon_issue_ready", 32'(bus.issue_ready), 32'(m_cnt[bus.issue_dest] != 2'd3));
            if (bus.reg_write_enable === 1'b1) writes_seen++;
            if (bus.alu_ready === 1'b0) saw_throttle = 1'b1;
        end
    end

    initial begin
        int base_writes;
        bus.alu_valid   = 1'b0; bus.alu_dest  = '0; bus.alu_data  = '0;
        bus.load_valid  = 1'b0; bus.load_dest = '0; bus.load_data = '0;
        bus.issue_valid = 1'b0; bus.issue_dest = '0;
        clear = 1'b1;

        // Reset state
        tick();
        tick();
        clear = 1'b0;
        checking = 1'b1;
        check("rst_we",          32'(bus.reg_write_enable), 32'd0);
        check("rst_write_reg",   32'(bus.write_reg),        32'd0);
        check("rst_write_data",  32'(bus.write_data),       32'd0);
        check("rst_pending",     32'(bus.pending),          32'd0);
        check("rst_alu_ready",   32'(bus.alu_ready),        32'd1);
        check("rst_load_ready",  32'(bus.load_ready),       32'd1);
        check("rst_issue_ready", 32'(bus.issue_ready),      32'd1);
        tick();

        // Single ALU result: strobe one cycle after acceptance
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd5; bus.alu_data = 18'h2A5A3;
        tick();
        bus.alu_valid = 1'b0;
        check("single_we_n", 32'(bus.reg_write_enable), 32'd0);
        tick();
        check("single_we",   32'(bus.reg_write_enable), 32'd1);
        check("single_reg",  32'(bus.write_reg),        32'd5);
        check("single_data", 32'(bus.write_data),       32'h2A5A3);
        tick();
        check("single_we_off", 32'(bus.reg_write_enable), 32'd0);
        check("hold_reg",      32'(bus.write_reg),        32'd5);
        check("hold_data",     32'(bus.write_data),       32'h2A5A3);

        // Load and ALU together: load written first
        bus.load_valid = 1'b1; bus.load_dest = 4'd2; bus.load_data = 18'd1;
        bus.alu_valid  = 1'b1; bus.alu_dest  = 4'd3; bus.alu_data  = 18'd7;
        tick();
        bus.load_valid = 1'b0; bus.alu_valid = 1'b0;
        tick();
        check("dual_first_reg",  32'(bus.write_reg),  32'd2);
        check("dual_first_data", 32'(bus.write_data), 32'd1);
        tick();
        check("dual_second_reg",  32'(bus.write_reg),  32'd3);
        check("dual_second_data", 32'(bus.write_data), 32'd7);
        tick();
        check("dual_empty_we",   32'(bus.reg_write_enable), 32'd0);
        check("dual_empty_lrdy", 32'(bus.load_ready),       32'd1);
        check("dual_empty_ardy", 32'(bus.alu_ready),        32'd1);

        // Sustained dual input for 10 cycles
        saw_throttle = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.load_valid = 1'b1; bus.load_dest = 4'(k);     bus.load_data = 18'(k + 18'h01000);
            bus.alu_valid  = 1'b1; bus.alu_dest  = 4'(k + 8); bus.alu_data  = 18'(k + 18'h02000);
            tick();
        end
        bus.load_valid = 1'b0; bus.alu_valid = 1'b0;
        check("sat_alu_throttled", 32'(saw_throttle), 32'd1);
        repeat (DEPTH + 2) tick();
        check("sat_drained_we", 32'(bus.reg_write_enable), 32'd0);
        check("sat_no_loss",    32'(writes_seen),          32'(pushes));

        // Scoreboard saturation on register 7
        bus.issue_valid = 1'b1; bus.issue_dest = 4'd7;
        repeat (3) tick();
        check("sb_ready_low", 32'(bus.issue_ready), 32'd0);
        check("sb_pend7",     32'(bus.pending[7]),  32'd1);
        // Keep issuing 7 while a write to 7 drains: rejected at count 3,
        // accepted once the write brings it back to 2, ending at 3 again.
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd7; bus.alu_data = 18'h00111;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        check("sb_wr7_we",    32'(bus.reg_write_enable), 32'd1);
        check("sb_wr7_ready", 32'(bus.issue_ready),      32'd0);
        tick();
        check("sb_after_dec_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        check("sb_back_at3_ready",  32'(bus.issue_ready), 32'd0);
        bus.issue_valid = 1'b0;
        // Three writes to 7 retire the remaining count
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd7;
        for (int k = 0; k < 3; k++) begin
            bus.alu_data = 18'(18'h00200 + k);
            tick();
        end
        bus.alu_valid = 1'b0;
        tick();
        check("sb_pend7_after2", 32'(bus.pending[7]), 32'd1);
        tick();
        check("sb_pend7_after3", 32'(bus.pending[7]), 32'd0);
        tick();

        // Clear mid-drain
        bus.issue_valid = 1'b1;
        for (int k = 4; k < 8; k++) begin
            bus.issue_dest = 4'(k);
            tick();
        end
        bus.issue_valid = 1'b0;
        bus.load_valid = 1'b1; bus.load_dest = 4'd4; bus.load_data = 18'h00044;
        bus.alu_valid  = 1'b1; bus.alu_dest  = 4'd5; bus.alu_data  = 18'h00055;
        tick();
        bus.load_dest = 4'd6; bus.load_data = 18'h00066;
        bus.alu_dest  = 4'd7; bus.alu_data  = 18'h00077;
        tick();
        check("clr_pre_pending", 32'(bus.pending),          32'h00F0);
        check("clr_pre_we",      32'(bus.reg_write_enable), 32'd1);
        clear = 1'b1;
        bus.issue_valid = 1'b1; bus.issue_dest = 4'd9;
        tick();
        clear = 1'b0;
        bus.load_valid = 1'b0; bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
        check("clr_we",         32'(bus.reg_write_enable), 32'd0);
        check("clr_pending",    32'(bus.pending),          32'd0);
        check("clr_load_ready", 32'(bus.load_ready),       32'd1);
        check("clr_alu_ready",  32'(bus.alu_ready),        32'd1);
        check("clr_write_reg",  32'(bus.write_reg),        32'd0);
        check("clr_write_data", 32'(bus.write_data),       32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("clr_no_write", 32'(bus.reg_write_enable), 32'd0);
        end

        // Pointer wrap: nine back-to-back singles
        base_writes = writes_seen;
        bus.alu_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.alu_dest = 4'(k + 1);
            bus.alu_data = 18'(18'h30000 + k * 3);
            tick();
        end
        bus.alu_valid = 1'b0;
        repeat (4) tick();
        check("wrap_count",   32'(writes_seen - base_writes), 32'd9);
        check("wrap_no_loss", 32'(writes_seen + dropped),     32'(pushes));

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
